alu_mul_seq: RTL and testbench
==============================

# alu_mul_seq

Multi-cycle 32x32 multiply sequencer that borrows the single-cycle ALU's add/sub datapath instead of instantiating its own multiplier. It runs a radix-2 shift-add algorithm, driving the ALU operand and opcode inputs each cycle and capturing its result and carry. It sits beside the ALU in the execute stage; the core stalls on `busy` and retires on `done`.

## Interface

- No parameters; datapath width fixed at 32 (ALU width).
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `a`  in  32  multiplicand, sampled with `start`
- `b`  in  32  multiplier, sampled with `start`
- `sgn`  in  1  signed operands (present only with `MUL_SIGNED_EN`), sampled with `start`
- `busy`  out  1  high from the edge accepting `start` until `done` falls
- `done`  out  1  one-cycle pulse; product valid
- `prod_hi`  out  32  product bits [63:32], registered
- `prod_lo`  out  32  product bits [31:0], registered
- `alu_a`  out  32  ALU operand A
- `alu_b`  out  32  ALU operand B
- `alu_op`  out  3  ALU opcode: 3'b010 add, 3'b110 sub
- `alu_result`  in  32  ALU result, same-cycle combinational
- `alu_carryout`  in  1  ALU carry out (valid for add)

## Operation

- Registers: `hi`[31:0], `lo`[31:0], `mcand`[31:0], `cnt`[5:0], `neg`[1:0], state.
- States: IDLE, NEG_A, NEG_B, RUN, FIX_LO, FIX_HI, DONE. NEG_*/FIX_* exist only with `MUL_SIGNED_EN`.
- IDLE: `start`=1 -> load `mcand`=a, `lo`=b, `hi`=0, `cnt`=0; go RUN (or NEG_A if `sgn`=1). `start` outside IDLE is ignored, operands not sampled.
- RUN: `alu_op`=010, `alu_a`=`hi`, `alu_b`= `lo[0]` ? `mcand` : 0. Edge: {`hi`,`lo`} <= {`alu_carryout`, `alu_result`, `lo[31:1]`}; `cnt`++. At `cnt`=31 go DONE (FIX_LO if signed).
- DONE: `done`=1 for one cycle; `prod_hi`/`prod_lo` already equal {`hi`,`lo`}; return IDLE.
- `prod_hi`/`prod_lo` update only on the edge entering DONE; hold until next DONE.
- Outside RUN/NEG/FIX: `alu_a`=0, `alu_b`=0, `alu_op`=010.
- Unsigned arithmetic; product exact in 64 bits; no overflow flag.

## Timing

- Reset (async): state IDLE, `busy`=0, `done`=0, `prod_hi`=`prod_lo`=0, all internal regs 0. Reset mid-operation aborts immediately; no `done`; next `start` after release accepted normally.
- Let E0 = edge sampling `start` in IDLE. Unsigned: RUN iterations on E1..E32; `done`=1 between E32 and E33; back-to-back `start` accepted earliest at E33.
- Signed (`sgn`=1): NEG_A at E1, NEG_B at E2, RUN E3..E34, FIX_LO E35, FIX_HI E36, `done` between E36 and E37. Latency fixed per mode, independent of operand values.
- `busy` goes high at E0, low at the edge leaving DONE.
- ALU path is combinational within one cycle; no ALU pipelining assumed.

## Configuration

- `MUL_SIGNED_EN` defined: `sgn` port present; signed two's-complement multiply:
  - NEG_A: `alu_op`=110, `alu_a`=0, `alu_b`=`mcand`; if `mcand[31]` load `mcand`<=result, `neg[0]`<=1.
  - NEG_B: same on `lo`, `neg[1]`.
  - FIX_LO: if `neg[0]`^`neg[1]`: sub 0-`lo` -> `lo`; record `lo_was_zero`.
  - FIX_HI: if negating: add `alu_a`=~`hi`, `alu_b`={31'b0,`lo_was_zero`} -> `hi`.
  - FIX states always spend their cycle (fixed latency) even when no negation.
- Undefined: no `sgn` port, unsigned only, NEG/FIX logic absent; `sgn`=0 behaviour in either build is identical.

## Test plan

- a=3, b=5, start at E0 -> `done` pulse after E32, `prod_hi`=0, `prod_lo`=0x0000000F, `busy` high E0..E33.
- a=b=0xFFFFFFFF -> `prod_hi`=0xFFFFFFFE, `prod_lo`=0x00000001 (exercises `alu_carryout`).
- a=0, b=0x12345678 -> product 0; `start` pulsed again at E10 with a=7 -> ignored, result still 0, single `done`.
- Reset asserted at E15 of a run -> outputs 0 asynchronously, no `done`; fresh 2x2 run afterward -> `prod_lo`=4.
- `MUL_SIGNED_EN`, sgn=1: a=-3, b=5 -> {hi,lo}=0xFFFFFFFF_FFFFFFF1, `done` after E36; a=0x80000000, b=-1 -> 0x00000000_80000000.
- `MUL_SIGNED_EN`, sgn=0: a=0xFFFFFFFF, b=2 -> 0x00000001_FFFFFFFE, `done` after E32.

Source files
------------

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: multi-cycle 32x32 multiply sequencer that reuses the external
// single-cycle ALU (add/sub) for a radix-2 shift-add loop.
//
// Optional feature macro: MUL_SIGNED_EN
//   defined   -> i_sgn port present, two's-complement signed multiply via
//                operand negation (NEG_A/NEG_B) and product fix-up (FIX_LO/FIX_HI)
//   undefined -> unsigned multiply only
//
// Ports:
//   i_clk, i_rst             clock, async active-high reset
//   i_start, i_a, i_b, i_sgn request and operands (sampled when idle)
//   o_busy, o_done           busy level, one-cycle completion pulse
//   o_prod_hi, o_prod_lo     registered 64-bit product
//   o_alu_a/o_alu_b/o_alu_op ALU operand/opcode drive (combinational)
//   i_alu_result/carryout    same-cycle ALU result and carry
module alu_mul_seq (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
`ifdef MUL_SIGNED_EN
  input  logic        i_sgn,
`endif
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_prod_hi,
  output logic [31:0] o_prod_lo,
  output logic [31:0] o_alu_a,
  output logic [31:0] o_alu_b,
  output logic [2:0]  o_alu_op,
  input  logic [31:0] i_alu_result,
  input  logic        i_alu_carryout
);

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE, S_NEG_A, S_NEG_B, S_RUN, S_FIX_LO, S_FIX_HI, S_DONE
  } state_t;

  state_t      r_state;
  logic [31:0] r_hi, r_lo, r_mcand;
  logic [5:0]  r_cnt;
  logic        w_sgn;
  logic [31:0] w_hi_nx, w_lo_nx;

`ifdef MUL_SIGNED_EN
  logic [1:0]  r_neg;
  logic        r_sgn;
  logic        r_lo_was_zero;
  logic        w_fix;
  assign w_sgn = i_sgn;
  // product needs negating when exactly one operand was negative
  assign w_fix = r_neg[0] ^ r_neg[1];
`else
  assign w_sgn = 1'b0;
`endif

  // shift-add step: carry enters the top of hi, result LSB drops into lo
  assign w_hi_nx = {i_alu_carryout, i_alu_result[31:1]};
  assign w_lo_nx = {i_alu_result[0], r_lo[31:1]};

  always_comb begin
    o_alu_op = OP_ADD;
    o_alu_a  = '0;
    o_alu_b  = '0;
    case (r_state)
      S_RUN: begin
        o_alu_a = r_hi;
        o_alu_b = r_lo[0] ? r_mcand : 32'd0;
      end
`ifdef MUL_SIGNED_EN
      S_NEG_A: begin
        o_alu_op = OP_SUB;
        o_alu_b  = r_mcand;
      end
      S_NEG_B, S_FIX_LO: begin
        o_alu_op = OP_SUB;
        o_alu_b  = r_lo;
      end
      // upper half of a 64-bit negate: ~hi plus the borrow-free carry
      S_FIX_HI: begin
        o_alu_a = ~r_hi;
        o_alu_b = {31'd0, r_lo_was_zero};
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_hi      <= '0;
      r_lo      <= '0;
      r_mcand   <= '0;
      r_cnt     <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_prod_hi <= '0;
      o_prod_lo <= '0;
`ifdef MUL_SIGNED_EN
      r_neg         <= '0;
      r_sgn         <= 1'b0;
      r_lo_was_zero <= 1'b0;
`endif
    end else begin
      o_done <= 1'b0;
      case (r_state)
        // DONE returns to idle on its edge, so a start seen there is taken
        // directly to allow back-to-back operations without a gap cycle.
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_mcand <= i_a;
            r_lo    <= i_b;
            r_hi    <= '0;
            r_cnt   <= '0;
            o_busy  <= 1'b1;
            r_state <= w_sgn ? S_NEG_A : S_RUN;
`ifdef MUL_SIGNED_EN
            r_neg <= '0;
            r_sgn <= i_sgn;
`endif
          end else begin
            o_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_hi  <= w_hi_nx;
          r_lo  <= w_lo_nx;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) begin
`ifdef MUL_SIGNED_EN
            if (r_sgn) begin
              r_state <= S_FIX_LO;
            end else begin
              r_state   <= S_DONE;
              o_done    <= 1'b1;
              o_prod_hi <= w_hi_nx;
              o_prod_lo <= w_lo_nx;
            end
`else
            r_state   <= S_DONE;
            o_done    <= 1'b1;
            o_prod_hi <= w_hi_nx;
            o_prod_lo <= w_lo_nx;
`endif
          end
        end
`ifdef MUL_SIGNED_EN
        S_NEG_A: begin
          if (r_mcand[31]) begin
            r_mcand  <= i_alu_result;
            r_neg[0] <= 1'b1;
          end
          r_state <= S_NEG_B;
        end
        S_NEG_B: begin
          if (r_lo[31]) begin
            r_lo     <= i_alu_result;
            r_neg[1] <= 1'b1;
          end
          r_state <= S_RUN;
        end
        S_FIX_LO: begin
          if (w_fix) r_lo <= i_alu_result;
          r_lo_was_zero <= (r_lo == 32'd0);
          r_state       <= S_FIX_HI;
        end
        S_FIX_HI: begin
          if (w_fix) r_hi <= i_alu_result;
          o_prod_hi <= w_fix ? i_alu_result : r_hi;
          o_prod_lo <= r_lo;
          o_done    <= 1'b1;
          r_state   <= S_DONE;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
module tb_alu_mul_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic        sgn;
  logic        busy, done;
  logic [31:0] prod_hi, prod_lo, alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic        alu_carryout;
  logic [32:0] alu_sum;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [63:0] prod;
    int          at;
  } exp_t;
  exp_t q[$];
  logic [63:0] last_prod = '0;

  alu_mul_seq dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_a(a), .i_b(b),
`ifdef MUL_SIGNED_EN
    .i_sgn(sgn),
`endif
    .o_busy(busy), .o_done(done), .o_prod_hi(prod_hi), .o_prod_lo(prod_lo),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
    .i_alu_result(alu_result), .i_alu_carryout(alu_carryout)
  );

  // reference single-cycle ALU
  assign alu_sum      = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_result   = (alu_op == 3'b110) ? (alu_a - alu_b) : alu_sum[31:0];
  assign alu_carryout = alu_sum[32];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboard: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        chk("spurious_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("product", {prod_hi, prod_lo}, e.prod);
        chk("latency", 64'(cyc), 64'(e.at));
        last_prod = e.prod;
      end
    end
  end

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic s);
    exp_t e;
    logic signed [63:0] sa, sb;
    sa = {{32{ta[31]}}, ta};
    sb = {{32{tb_[31]}}, tb_};
    e.prod = s ? 64'(sa * sb) : ({32'd0, ta} * {32'd0, tb_});
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_; sgn = s;
    e.at = cyc + 1 + (s ? 36 : 32);
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_e0", 64'(busy), 64'd1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !busy) begin ok = 1'b1; break; end
    end
    if (!ok) chk("timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int e0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; sgn = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_prod", {prod_hi, prod_lo}, 64'd0);
    chk("rst_alu", {29'd0, alu_op, alu_a}, {29'd0, 3'b010, 32'd0});
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 3 x 5 with explicit busy/done window
    run_op(32'd3, 32'd5, 1'b0);
    e0 = cyc;
    while (cyc < e0 + 32) @(negedge clk);
    chk("busy_e32", 64'(busy), 64'd1);
    chk("done_e32", 64'(done), 64'd1);
    @(negedge clk);
    chk("busy_e33", 64'(busy), 64'd0);
    chk("done_e33", 64'(done), 64'd0);
    wait_idle();
    repeat (5) @(negedge clk);
    chk("prod_hold", {prod_hi, prod_lo}, 64'h0000_0000_0000_000F);

    // carry-out path
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_idle();

    // start mid-run ignored
    run_op(32'd0, 32'h1234_5678, 1'b0);
    e0 = cyc;
    while (cyc < e0 + 9) @(negedge clk);
    start = 1'b1; a = 32'd7; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);
    chk("no_extra_busy", 64'(busy), 64'd0);

    // async reset mid-operation
    run_op(32'h0000_1234, 32'h0000_5678, 1'b0);
    e0 = cyc;
    while (cyc < e0 + 15) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    q.delete();
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_prod", {prod_hi, prod_lo}, 64'd0);
    chk("midrst_alu", {alu_a, alu_b}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_idle", 64'(busy), 64'd0);
    run_op(32'd2, 32'd2, 1'b0);
    wait_idle();
    chk("after_rst_lo", 64'(prod_lo), 64'd4);

    // random unsigned
    for (int i = 0; i < 4; i++) begin
      run_op($urandom, $urandom, 1'b0);
      wait_idle();
    end

`ifdef MUL_SIGNED_EN
    run_op(32'hFFFF_FFFD, 32'd5, 1'b1);
    wait_idle();
    chk("s_m3x5", {prod_hi, prod_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_idle();
    chk("s_minx_m1", {prod_hi, prod_lo}, 64'h0000_0000_8000_0000);
    run_op(32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_idle();
    chk("u_in_sbuild", {prod_hi, prod_lo}, 64'h0000_0001_FFFF_FFFE);
    run_op(32'h0, 32'hFFFF_FFF0, 1'b1);
    wait_idle();
    for (int i = 0; i < 3; i++) begin
      run_op($urandom, $urandom, 1'b1);
      wait_idle();
    end
`endif

    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
